// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths and types for the CPU counter users.
`timescale 1ns/100ps
package cpu_pkg;
    localparam int CNT_WIDTH_DEFAULT = 4;
    typedef logic [CNT_WIDTH_DEFAULT-1:0] cnt_t;
endpackage

// File: rtl/counter.sv
// counter: loadable free-running up-counter with terminal-count decode.
`timescale 1ns/100ps
module counter
    import cpu_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= RESET_VAL;
        else        count <= load ? load_val : count + 1'b1;
    assign tc = &count;
`ifndef SYNTHESIS
    // $past(rst_n) gates out the first edge after reset release
    a_load: assert property (@(posedge clk) disable iff (!rst_n)
        $past(rst_n) && $past(load) |-> count == $past(load_val));
    a_inc: assert property (@(posedge clk) disable iff (!rst_n)
        $past(rst_n) && !$past(load) |-> count == WIDTH'($past(count) + 1'b1));
    a_rst: assert property (@(posedge clk) !rst_n |-> count == RESET_VAL);
`endif
endmodule

// File: tb/tb_counter.sv
// tb_counter: directed scoreboard bench for counter.
`timescale 1ns/100ps
module tb_counter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       tc;
    logic [3:0] sb[$];
    int checks = 0;
    int errors = 0;
    counter dut (.clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .count(count), .tc(tc));
    always #1 clk = ~clk;
    task automatic chk(input string tag);
        logic [3:0] e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, count);
        end
        e = sb.size() != 0 ? sb.pop_front() : 4'hx;
        checks++;
        assert (count === e) else begin
            errors++;
            $error("FAIL %s count observed=%h expected=%h", tag, count, e);
        end
        checks++;
        assert (tc === (e == 4'hF)) else begin
            errors++;
            $error("FAIL %s tc observed=%b expected=%b", tag, tc, e == 4'hF);
        end
    endtask
    task automatic cyc(input string tag, input logic ld, input logic [3:0] v, input logic [3:0] exp);
        load = ld;
        load_val = v;
        sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        chk(tag);
    endtask
    initial begin
        rst_n = 1'b0;
        load = 1'b0;
        load_val = 4'h0;
        repeat (2) @(negedge clk);
        sb.push_back(4'h0);
        chk("reset");
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) cyc("count", 1'b0, 4'h0, 4'(i));
        cyc("load7", 1'b1, 4'h7, 4'h7);
        cyc("after7", 1'b0, 4'h0, 4'h8);
        cyc("after7", 1'b0, 4'h0, 4'h9);
        cyc("reload4", 1'b1, 4'h4, 4'h4);
        cyc("after4", 1'b0, 4'hB, 4'h5);
        cyc("after4", 1'b0, 4'hB, 4'h6);
        cyc("loadE", 1'b1, 4'hE, 4'hE);
        cyc("wrapF", 1'b0, 4'h0, 4'hF);
        cyc("wrap0", 1'b0, 4'h0, 4'h0);
        cyc("wrap1", 1'b0, 4'h0, 4'h1);
        cyc("loadF", 1'b1, 4'hF, 4'hF);
        cyc("wrapF0", 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) cyc("hold3", 1'b1, 4'h3, 4'h3);
        cyc("release", 1'b0, 4'h0, 4'h4);
        load = 1'b1;
        load_val = 4'h9;
        #0.5 rst_n = 1'b0;
        #0.2;
        sb.push_back(4'h0);
        chk("async_rst");
        @(posedge clk);
        @(negedge clk);
        sb.push_back(4'h0);
        chk("rst_over_load");
        rst_n = 1'b1;
        cyc("post_rst", 1'b0, 4'h0, 4'h1);
        cyc("post_rst", 1'b0, 4'h0, 4'h2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
